timer_device: RTL and testbench



---
 rtl/timer_device_if.sv | 14 +
 rtl/timer_device.sv | 99 +++++++++
 tb/tb_timer_device.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_device_if.sv
// CPU data-bus port of the memory-mapped down-counter timer.
// The CPU/bridge side drives address, write enable and data; the timer answers with read data and its interrupt request.
interface timer_device_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       addr;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             irq;

    modport master (output addr, output we, output wd, input rd, input irq);
    modport slave  (input addr, input we, input wd, output rd, output irq);
endinterface

// File: rtl/timer_device.sv
// Programmable down-counter timer with one-shot and auto-reload modes.
// A CPU write to CTRL clears irq_flag.
module timer_device #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    timer_device_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t           state_reg;
    logic [3:0]       ctrl_reg;
    logic [WIDTH-1:0] preset_reg;
    logic [WIDTH-1:0] count_reg;
    logic             irq_flag_reg;

    logic enable;
    logic auto_reload;

    assign enable      = ctrl_reg[0];
    assign auto_reload = (ctrl_reg[2:1] == 2'b01);

    // CPU writes come after the FSM updates, so a write to CTRL wins on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= '0;
            count_reg    <= '0;
            irq_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (count_reg > WIDTH'(1)) begin
                        count_reg <= count_reg - WIDTH'(1);
                    end else begin
                        count_reg    <= '0;
                        irq_flag_reg <= 1'b1;
                        state_reg    <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        irq_flag_reg <= 1'b0;
                        state_reg    <= LOAD;
                    end else begin
                        ctrl_reg[0] <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (bus.we) begin
                case (bus.addr)
                    ADDR_CTRL: begin
                        ctrl_reg     <= bus.wd[3:0];
                        irq_flag_reg <= 1'b0;
                    end
                    ADDR_PRESET: preset_reg <= bus.wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            ADDR_CTRL:   bus.rd = {{(WIDTH - 4){1'b0}}, ctrl_reg};
            ADDR_PRESET: bus.rd = preset_reg;
            ADDR_COUNT:  bus.rd = count_reg;
            default:     bus.rd = '0;
        endcase
    end

    assign bus.irq = ctrl_reg[3] & irq_flag_reg;
endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: a per-edge vector table for the auto-reload trace,
// plus hand-written sequences for one-shot, stop/restart, masking, reset and same-edge write cases.
module tb_timer_device;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    timer_device_if #(.WIDTH(WIDTH)) bus ();

    timer_device #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [31:0] exp;
        bit          is_irq;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [1:0]  wa;
        logic [31:0] wdat;
        logic [31:0] cnt;
        logic        irq;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_rd(input string n, input logic [1:0] a, input logic [31:0] e);
        exp_t r;
        r.name = n; r.sel = a; r.exp = e; r.is_irq = 1'b0;
        sb.push_back(r);
    endtask

    task automatic expect_irq(input string n, input logic e);
        exp_t r;
        r.name = n; r.sel = 2'd0; r.exp = {31'd0, e}; r.is_irq = 1'b1;
        sb.push_back(r);
    endtask

    // Called half a period away from the rising edge; each read settles for 1 ns.
    task automatic check_all();
        exp_t r;
        logic [31:0] got;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.is_irq) begin
                got = {31'd0, bus.irq};
            end else begin
                bus.addr = r.sel;
                #1;
                got = bus.rd;
            end
            checks++;
            if (got !== r.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", r.name, got, r.exp);
            end else begin
                $display("ok   %s: 0x%0h", r.name, got);
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wd = d;
        @(negedge clk);
        bus.we = 1'b0; bus.wd = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Auto-reload, PRESET=3: row i is edge E_i; stray writes to COUNT and addr 3 must be ignored.
        vecs[0]  = '{1'b1, 2'd0, 32'hB,  32'd0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,  32'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,  32'd3, 1'b0};
        vecs[3]  = '{1'b1, 2'd2, 32'h55, 32'd2, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,  32'd1, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,  32'd0, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 32'h0,  32'd0, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,  32'd3, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 32'h55, 32'd2, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 32'h0,  32'd1, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 32'h0,  32'd0, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 32'h0,  32'd0, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 32'h0,  32'd3, 1'b0};

        reset = 1'b1;
        bus.we = 1'b0; bus.addr = 2'd0; bus.wd = '0;
        step(2);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) expect_rd($sformatf("reset_rd_a%0d", a), 2'(a), 32'd0);
        expect_irq("reset_irq", 1'b0);
        check_all();

        // One-shot, PRESET=5, IM set
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        step(2);
        expect_rd("os_count_e2", 2'd2, 32'd5);
        expect_irq("os_irq_e2", 1'b0);
        check_all();
        step(4);
        expect_rd("os_count_e6", 2'd2, 32'd1);
        expect_irq("os_irq_e6", 1'b0);
        check_all();
        step(1);
        expect_rd("os_count_e7", 2'd2, 32'd0);
        expect_irq("os_irq_e7", 1'b1);
        check_all();
        step(1);
        expect_rd("os_ctrl_e8", 2'd0, 32'h8);
        check_all();
        for (int i = 0; i < 20; i++) begin
            step(1);
            expect_irq($sformatf("os_irq_hold%0d", i), 1'b1);
            check_all();
        end
        bus_write(2'd0, 32'h8);
        expect_irq("os_irq_cleared", 1'b0);
        expect_rd("os_ctrl_after_clr", 2'd0, 32'h8);
        check_all();

        // Auto-reload trace from the vector table
        do_reset();
        bus_write(2'd1, 32'd3);
        for (int i = 0; i < 13; i++) begin
            bus.we = vecs[i].wr; bus.addr = vecs[i].wa; bus.wd = vecs[i].wdat;
            expect_rd($sformatf("ar_count_e%0d", i), 2'd2, vecs[i].cnt);
            expect_irq($sformatf("ar_irq_e%0d", i), vecs[i].irq);
            @(negedge clk);
            bus.we = 1'b0; bus.wd = '0;
            check_all();
        end

        // Stop mid-count, then restart from PRESET
        do_reset();
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h1);
        step(5);
        expect_rd("stop_count_e5", 2'd2, 32'd7);
        check_all();
        bus_write(2'd0, 32'h8);
        expect_rd("stop_count_e6", 2'd2, 32'd6);
        check_all();
        step(3);
        expect_rd("stop_count_held", 2'd2, 32'd6);
        expect_irq("stop_irq", 1'b0);
        expect_rd("stop_ctrl", 2'd0, 32'h8);
        check_all();
        bus_write(2'd0, 32'h1);
        step(1);
        expect_rd("restart_count_load", 2'd2, 32'd6);
        check_all();
        step(1);
        expect_rd("restart_count_reloaded", 2'd2, 32'd10);
        check_all();

        // Masked one-shot, PRESET=2
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        step(4);
        expect_rd("mask_count_e4", 2'd2, 32'd0);
        expect_irq("mask_irq_e4", 1'b0);
        check_all();
        step(1);
        expect_rd("mask_ctrl_e5", 2'd0, 32'h0);
        expect_irq("mask_irq_e5", 1'b0);
        check_all();
        bus_write(2'd0, 32'h8);
        step(2);
        expect_irq("mask_irq_after_unmask", 1'b0);
        check_all();

        // PRESET=0 behaves like PRESET=1
        do_reset();
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        step(2);
        expect_rd("n0_count_e2", 2'd2, 32'd0);
        expect_irq("n0_irq_e2", 1'b0);
        check_all();
        step(1);
        expect_irq("n0_irq_e3", 1'b1);
        check_all();

        // Same-edge CTRL writes: against irq_flag set, then against the Enable clear in INT
        do_reset();
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h9);
        step(2);
        bus_write(2'd0, 32'h9);
        expect_irq("sim_flag_cleared", 1'b0);
        expect_rd("sim_ctrl_e3", 2'd0, 32'h9);
        check_all();
        bus_write(2'd0, 32'h9);
        expect_rd("sim_ctrl_wins_int", 2'd0, 32'h9);
        expect_irq("sim_irq_e4", 1'b0);
        check_all();

        // Reset mid-count in auto-reload mode
        do_reset();
        bus_write(2'd1, 32'd4);
        bus_write(2'd0, 32'hB);
        step(2);
        bus_write(2'd2, 32'h55);
        expect_rd("rst_count_e3", 2'd2, 32'd3);
        check_all();
        step(1);
        expect_rd("rst_count_e4", 2'd2, 32'd2);
        check_all();
        do_reset();
        for (int a = 0; a < 3; a++) expect_rd($sformatf("rst_mid_rd_a%0d", a), 2'(a), 32'd0);
        expect_irq("rst_mid_irq", 1'b0);
        check_all();
        step(6);
        expect_rd("rst_idle_count", 2'd2, 32'd0);
        expect_irq("rst_idle_irq", 1'b0);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
